// File: rtl/spiflash_pkg.sv
// Shared SPI flash definitions: opcodes and responder state encoding,
// usable by both initiator and responder sides.
package spiflash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WAKE  = 8'hAB;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam int         ADDR_LEN = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spiflash_if.sv
// Four-wire SPI flash bus; the initiator is the master, the flash model the slave.
interface spiflash_if;

  logic flash_csb;
  logic flash_clk;
  logic flash_io0;
  logic flash_io1;

  modport master (
    output flash_csb,
    output flash_clk,
    output flash_io0,
    input  flash_io1
  );

  modport slave (
    input  flash_csb,
    input  flash_clk,
    input  flash_io0,
    output flash_io1
  );

endinterface

// File: rtl/spiflash_ram.sv
// Byte array behind the flash model: one synchronous write port and one
// asynchronous read port, so a same-cycle read sees the pre-write byte.
module spiflash_ram #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spiflash_resp.sv
// SPI flash responder model (mode 3, clk-synchronous SCK): READ streams bytes
// from an internal array with address wrap, WAKE sets the awake flag.
module spiflash_resp
  import spiflash_pkg::*;
#(
  parameter int         ADDR_BITS = 16,
  parameter logic [7:0] CMD_READ  = OP_READ,
  parameter logic [7:0] CMD_WAKE  = OP_WAKE
) (
  input  logic                 clk,
  input  logic                 resetn,
  spiflash_if.slave            spi,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 awake,
  output logic                 busy
);

  spi_state_e           state;
  logic                 sck_q;
  logic                 rise;
  logic                 armed;
  logic                 miso_q;
  logic [4:0]           bit_cnt;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-2:0] addr_sr;
  logic [6:0]           data_sr;
  logic [ADDR_BITS-1:0] next_addr;
  logic [ADDR_BITS-1:0] addr_full;
  logic [7:0]           cmd_full;
  logic [ADDR_BITS-1:0] ram_raddr;
  logic [7:0]           ram_rdata;

  assign rise      = spi.flash_clk & ~sck_q & ~spi.flash_csb;
  // Address bits above ADDR_BITS simply fall off the top of the shifter.
  assign addr_full = {addr_sr, spi.flash_io0};
  assign cmd_full  = {cmd_sr, spi.flash_io0};
  assign ram_raddr = (state == ST_ADDR) ? addr_full : next_addr;
  assign spi.flash_io1 = miso_q;

  spiflash_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (load_valid),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // armed is only set by seeing csb high, so a transfer cut by reset is
  // ignored until the initiator closes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sck_q     <= 1'b1;
      bit_cnt   <= '0;
      miso_q    <= 1'b0;
      awake     <= 1'b0;
      busy      <= 1'b0;
      armed     <= 1'b0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      next_addr <= '0;
    end else begin
      sck_q <= spi.flash_clk;
      busy  <= ~spi.flash_csb;
      if (spi.flash_csb) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        miso_q  <= 1'b0;
        armed   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= armed ? ST_CMD : ST_IGNORE;
          end
          ST_CMD: begin
            if (rise) begin
              cmd_sr <= cmd_full[6:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (cmd_full == CMD_READ) begin
                  state <= ST_ADDR;
                end else begin
                  if (cmd_full == CMD_WAKE) begin
                    awake <= 1'b1;
                  end
                  state <= ST_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              addr_sr <= addr_full[ADDR_BITS-2:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt   <= '0;
                miso_q    <= ram_rdata[7];
                data_sr   <= ram_rdata[6:0];
                next_addr <= addr_full + ADDR_BITS'(1);
                state     <= ST_DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_DATA: begin
            if (rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt   <= '0;
                miso_q    <= ram_rdata[7];
                data_sr   <= ram_rdata[6:0];
                next_addr <= next_addr + ADDR_BITS'(1);
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                miso_q  <= data_sr[6];
                data_sr <= {data_sr[5:0], 1'b0};
              end
            end
          end
          ST_IGNORE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spiflash_resp.sv
// Self-checking bench for spiflash_resp: directed scenarios plus randomized
// reads compared against a byte-array reference model.
module tb_spiflash_resp;
  import spiflash_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        awake;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int jitter = 0;
  logic [7:0] mem_model [65536];

  spiflash_if spi ();

  spiflash_resp #(
    .ADDR_BITS(16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi       (spi),
    .load_valid(load_valid),
    .load_addr (load_addr),
    .load_data (load_data),
    .awake     (awake),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One SCK period per bit: low phase drives MOSI, MISO sampled just before the rise.
  task automatic applyStimulus(input int nbits, input logic [63:0] tx,
                               output logic [63:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      spi.flash_clk = 1'b0;
      spi.flash_io0 = tx[i];
      @(posedge clk); #1;
      rx = {rx[62:0], spi.flash_io1};
      spi.flash_clk = 1'b1;
      if (jitter > 0) repeat ($urandom_range(jitter, 0)) @(posedge clk);
    end
  endtask

  task automatic load_byte(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic csb_low();
    @(posedge clk); #1;
    spi.flash_csb = 1'b0;
  endtask

  task automatic csb_high();
    @(posedge clk); #1;
    spi.flash_clk = 1'b1;
    spi.flash_csb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_miso", 64'(spi.flash_io1), 64'h0);
    checkOutput("reset_awake", 64'(awake), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    resetn = 1'b1;
  endtask

  initial begin
    logic [63:0] rx;
    logic [63:0] expv;
    logic [31:0] le;
    logic [15:0] base_lo;
    logic [7:0]  upper;
    int          nbytes;

    spi.flash_csb = 1'b1;
    spi.flash_clk = 1'b1;
    spi.flash_io0 = 1'b0;
    do_reset();

    // Sequential read of 8 bytes across an SCK pause.
    for (int i = 0; i < 8; i++) load_byte(16'h0010 + 16'(i), 8'(8'h11 * (i + 1)));
    csb_low();
    applyStimulus(32, {32'h0, OP_READ, 24'h000010}, rx);
    checkOutput("read_hdr_miso", rx, 64'h0);
    checkOutput("busy_active", 64'(busy), 64'h1);
    applyStimulus(32, 64'(32'hA5A5_5A5A), rx);
    le = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    checkOutput("read_first4", 64'(le), 64'h44332211);
    repeat (20) @(posedge clk);
    #1;
    applyStimulus(32, 64'h0, rx);
    le = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    checkOutput("read_next4", 64'(le), 64'h88776655);
    csb_high();
    checkOutput("busy_idle", 64'(busy), 64'h0);

    // Wrap at the top of the array and alias through the upper address bits.
    load_byte(16'hFFFF, 8'hAA);
    load_byte(16'h0000, 8'hBB);
    csb_low();
    applyStimulus(32, {32'h0, OP_READ, 24'h00FFFF}, rx);
    applyStimulus(16, 64'h0, rx);
    checkOutput("read_wrap", rx, 64'hAABB);
    csb_high();
    csb_low();
    applyStimulus(32, {32'h0, OP_READ, 24'h12FFFF}, rx);
    applyStimulus(8, 64'h0, rx);
    checkOutput("read_alias", rx, 64'hAA);
    csb_high();

    // Wake command, then an unsupported opcode.
    do_reset();
    csb_low();
    applyStimulus(8, 64'(OP_WAKE), rx);
    checkOutput("wake_miso", rx, 64'h0);
    csb_high();
    checkOutput("wake_awake", 64'(awake), 64'h1);
    csb_low();
    applyStimulus(24, {40'h0, OP_RDID, 16'hFFFF}, rx);
    checkOutput("rdid_miso", rx, 64'h0);
    csb_high();
    checkOutput("rdid_awake", 64'(awake), 64'h1);

    // csb pulse without SCK, then a command aborted inside the address.
    csb_low();
    csb_high();
    checkOutput("flick_miso", 64'(spi.flash_io1), 64'h0);
    csb_low();
    applyStimulus(20, {44'h0, OP_READ, 12'h000}, rx);
    csb_high();
    csb_low();
    applyStimulus(32, {32'h0, OP_READ, 24'h000010}, rx);
    applyStimulus(8, 64'h0, rx);
    checkOutput("after_abort", rx, 64'h11);
    csb_high();

    // Reset during DATA with csb held low: silent until csb cycles.
    csb_low();
    applyStimulus(32, {32'h0, OP_READ, 24'h000010}, rx);
    applyStimulus(8, 64'h0, rx);
    checkOutput("pre_reset_data", rx, 64'h11);
    do_reset();
    applyStimulus(40, {24'h0, OP_READ, 24'h000010, 8'h00}, rx);
    checkOutput("post_reset_ignore", rx, 64'h0);
    csb_high();
    csb_low();
    applyStimulus(32, {32'h0, OP_READ, 24'h000011}, rx);
    applyStimulus(8, 64'h0, rx);
    checkOutput("post_reset_read", rx, 64'h22);
    csb_high();

    // Randomized reads over a preloaded window, with SCK jitter.
    for (int i = 0; i < 32; i++) load_byte(16'h4000 + 16'(i), 8'($urandom));
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 3; k++) load_byte(16'h4000 + 16'($urandom_range(31, 0)), 8'($urandom));
      base_lo = 16'h4000 + 16'($urandom_range(27, 0));
      upper   = 8'($urandom);
      nbytes  = $urandom_range(4, 1);
      jitter  = $urandom_range(2, 0);
      expv = '0;
      for (int b = 0; b < nbytes; b++) expv = {expv[55:0], mem_model[16'(base_lo + 16'(b))]};
      csb_low();
      applyStimulus(32, {32'h0, OP_READ, upper, base_lo}, rx);
      checkOutput("rand_hdr", rx, 64'h0);
      applyStimulus(nbytes * 8, {$urandom, $urandom}, rx);
      checkOutput("rand_data", rx, expv);
      csb_high();
    end
    jitter = 0;

    $display("[TB] done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spiflash_resp.md
SPIFLASH_RESP -- requirements
Module: spiflash_resp

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, byte-address width of the internal array (2**ADDR_BITS bytes).
REQ-002 SHALL have parameter CMD_READ, default 8'h03, read opcode.
REQ-003 SHALL have parameter CMD_WAKE, default 8'hAB, release-power-down opcode.
REQ-004 SHALL have port clk  input  1  system clock, shared with the SPI initiator; the only clock.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port flash_csb  input  1  chip select, active low.
REQ-007 SHALL have port flash_clk  input  1  SCK, mode 3 (idles high), changes at most once per clk.
REQ-008 SHALL have port flash_io0  input  1  MOSI.
REQ-009 SHALL have port flash_io1  output  1  MISO, registered.
REQ-010 SHALL have port load_valid  input  1  array write strobe, always accepted.
REQ-011 SHALL have ports load_addr  input  ADDR_BITS  and  load_data  input  8  array write address/data.
REQ-012 SHALL have port awake  output  1  set by a completed CMD_WAKE command.
REQ-013 SHALL have port busy  output  1  registered copy of !flash_csb.

Function
REQ-014 SHALL treat SPI inputs as synchronous to clk (no synchronizers); sck_q register holds previous flash_clk.
REQ-015 SHALL detect rise = flash_clk & !sck_q & !flash_csb; all shifting happens only on rise cycles.
REQ-016 SHALL sample flash_io0 on each rise, MSB first.
REQ-017 SHALL update flash_io1 only at the clock edge ending a rise cycle, so it is stable through the following SCK-low phase when the initiator samples it.
REQ-018 FSM states: IDLE, CMD, ADDR, DATA, IGNORE; flash_csb high in any state -> IDLE next cycle, bit counter cleared, flash_io1 <= 0.
REQ-019 IDLE -> CMD when flash_csb low; CMD collects 8 bits.
REQ-020 After 8th command bit: CMD_READ -> ADDR; CMD_WAKE -> set awake, IGNORE; any other -> IGNORE.
REQ-021 ADDR collects 24 bits; only the low ADDR_BITS select the byte (upper bits ignored, address aliases).
REQ-022 On the rise of address bit 0, array SHALL be read asynchronously at {addr_sr[22:0], flash_io0}; byte loaded into MISO shift register, bit 7 driven at that edge; -> DATA.
REQ-023 DATA: each rise shifts next bit out; on rise of a byte's 8th bit, next byte (address+1, wrapping modulo 2**ADDR_BITS) loaded, its bit 7 driven at that edge; streaming is unbounded.
REQ-024 SCK may pause any number of cycles with flash_csb low; state and MISO held.
REQ-025 IGNORE: flash_io1 = 0, no state change until flash_csb high.
REQ-026 flash_io1 SHALL be 0 during CMD and ADDR.
REQ-027 load write takes effect at the clock edge; a same-cycle array read SHALL return the pre-write value.
REQ-028 flash_csb falling and rising in consecutive cycles with no SCK SHALL leave no side effects.

Reset
REQ-029 On resetn low: state IDLE, sck_q = 1, bit counter 0, flash_io1 = 0, awake = 0, busy = 0; array contents unchanged.
REQ-030 Reset mid-transfer SHALL abort; after release, flash_csb must go high before a new command is accepted (FSM waits in IGNORE if flash_csb already low).

Structure
REQ-031 Opcode constants SHALL live in a shared spiflash_pkg package for reuse by initiator and responder.
REQ-032 Byte array SHALL be one sub-module spiflash_ram (1 sync write port, 1 async read port).

Verification
REQ-033 Load bytes 0x10..0x17 = 11,22,33,44,55,66,77,88; initiator issues 03 000010, 32 bits -> rdata 32'h44332211.
REQ-034 Continue same transaction 32 more SCK after 20-cycle pause -> 32'h88776655.
REQ-035 Load 0xFFFF=AA, 0x0000=BB; read 03 00FFFF, 16 bits -> bytes AA, BB (wrap); read 03 12FFFF -> AA (alias).
REQ-036 After reset send AB (8 bits), csb high -> awake = 1 and flash_io1 = 0 throughout; opcode 9F -> awake unchanged, MISO 0.
REQ-037 Deassert csb after 12 address bits, then read 03 000010 -> 8'h11, no residue from aborted command.
REQ-038 Assert resetn low during DATA with csb held low -> flash_io1 = 0, no output until csb cycles high then low.
